regfile32_wr_port: RTL and testbench

//  32-entry x WIDTH register file, directly downstream of decoder32.

---
 rtl/regfile32_wr_port.sv | 97 +++++++++
 tb/tb_regfile32_wr_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile32_wr_port.sv
// 32-entry x WIDTH register file written through a one-hot select word.
// Two combinational read ports; register 0 reads as zero.
// Illegal select words (popcount != 1 while wr_en) set a sticky flag and
// bump a saturating counter. Both are cleared by err_clr; a new error in the
// same cycle takes priority over the clear.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).

module regfile32_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Single storage word; reset clears it, otherwise load on enable.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module regfile32_wr_port #(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [31:0]          wr_sel,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [4:0]           rd_addr0,
    input  logic [4:0]           rd_addr1,
    output logic [WIDTH-1:0]     rd_data0,
    output logic [WIDTH-1:0]     rd_data1,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [31:0][WIDTH-1:0] regs;
    logic                   sel_onehot;
    logic                   wr_legal;
    logic                   wr_illegal;

    // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
    assign sel_onehot = (wr_sel != 32'd0) && ((wr_sel & (wr_sel - 32'd1)) == 32'd0);
    assign wr_legal   = wr_en & sel_onehot;
    assign wr_illegal = wr_en & ~sel_onehot;

    // Entry 0 is a constant; writes that select it land nowhere.
    assign regs[0] = '0;

    // Each entry's enable comes straight from its select bit, no binary re-encode.
    for (genvar k = 1; k < 32; k++) begin : g_entry
        regfile32_entry #(.WIDTH(WIDTH)) u_entry (
            .clk (clk),
            .rst (rst),
            .we  (wr_legal & wr_sel[k]),
            .d   (wr_data),
            .q   (regs[k])
        );
    end

    // Read port 0: storage lookup, optionally forwarding a same-cycle legal write.
    always_comb begin
        rd_data0 = regs[rd_addr0];
`ifdef REGFILE_BYPASS_EN
        if (wr_legal && (rd_addr0 != 5'd0) && wr_sel[rd_addr0]) rd_data0 = wr_data;
`endif
    end

    // Read port 1: identical to port 0.
    always_comb begin
        rd_data1 = regs[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_legal && (rd_addr1 != 5'd0) && wr_sel[rd_addr1]) rd_data1 = wr_data;
`endif
    end

    // Sticky error flag and saturating counter; a fresh error beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else if (wr_illegal) begin
            sel_err <= 1'b1;
            if (err_clr)                err_cnt <= ERR_CNT_W'(1);
            else if (err_cnt != CNT_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end else if (err_clr) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_regfile32_wr_port.sv
// Randomized, self-checking bench for regfile32_wr_port against a
// behavioural model (array of registers, popcount rule, saturating counter).
module tb_regfile32_wr_port;
    localparam int WIDTH     = 32;
    localparam int ERR_CNT_W = 2;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 wr_en = 1'b0;
    logic [31:0]          wr_sel = '0;
    logic [WIDTH-1:0]     wr_data = '0;
    logic [4:0]           rd_addr0 = '0;
    logic [4:0]           rd_addr1 = '0;
    logic [WIDTH-1:0]     rd_data0;
    logic [WIDTH-1:0]     rd_data1;
    logic                 sel_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [WIDTH-1:0] m_regs [32];
    logic             m_err;
    int               m_cnt;

    regfile32_wr_port #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .sel_err(sel_err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Expected combinational read for the current inputs.
    function automatic logic [WIDTH-1:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && $countones(wr_sel) == 1 && wr_sel[a]) return wr_data;
`endif
        return m_regs[a];
    endfunction

    // Advance one clock and apply the behavioural rules to the model.
    task automatic tick();
        bit ill;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            ill = wr_en && ($countones(wr_sel) != 1);
            if (wr_en && !ill) begin
                for (int i = 1; i < 32; i++) if (wr_sel[i]) m_regs[i] = wr_data;
            end
            if (ill) begin
                m_err = 1'b1;
                m_cnt = err_clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
            end else if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i); #1;
            checks++;
            if (rd_data0 !== '0 || rd_data1 !== '0) begin
                errors++;
                $display("FAIL reset_read idx=%0d got %h/%h want 0", i, rd_data0, rd_data1);
            end
        end
        checks++;
        if (sel_err !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_err got sel_err=%b err_cnt=%0d want 0/0", sel_err, err_cnt);
        end
    endtask

    task automatic test_legal_writes();
        for (int k = 1; k < 32; k++) begin
            wr_en = 1'b1; wr_sel = 32'h1 << k; wr_data = 32'hA5A50000 + k; tick();
        end
        idle();
        for (int k = 0; k < 32; k++) begin
            rd_addr0 = 5'(k); rd_addr1 = 5'(k); #1;
            checks++;
            if (rd_data0 !== exp_rd(5'(k)) || rd_data1 !== exp_rd(5'(k)) ||
                (k != 0 && rd_data0 !== 32'hA5A50000 + k)) begin
                errors++;
                $display("FAIL legal_read k=%0d got %h/%h want %h", k, rd_data0, rd_data1, exp_rd(5'(k)));
            end
        end
        wr_en = 1'b1; wr_sel = 32'h1; wr_data = 32'hFFFFFFFF; rd_addr0 = 0; rd_addr1 = 0; #1;
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            errors++;
            $display("FAIL reg0_during_write got %h/%h want 0", rd_data0, rd_data1);
        end
        tick(); idle(); #1;
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reg0_write got %h/%h sel_err=%b want 0/0/0", rd_data0, rd_data1, sel_err);
        end
    endtask

    task automatic test_illegal();
        wr_en = 1'b1; wr_sel = 32'h1 << 5; wr_data = 32'h1234; tick();
        wr_en = 1'b0; err_clr = 1'b1; tick(); idle();
        wr_en = 1'b1; wr_sel = 32'h00000030; wr_data = 32'hDEAD; tick(); idle();
        rd_addr0 = 5'd4; rd_addr1 = 5'd5; #1;
        checks++;
        if (rd_data0 !== 32'hA5A50004 || rd_data1 !== 32'h1234) begin
            errors++;
            $display("FAIL illegal_no_write got r4=%h r5=%h want a5a50004/1234", rd_data0, rd_data1);
        end
        checks++;
        if (sel_err !== 1'b1 || err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL illegal_err1 got %b/%0d want 1/1", sel_err, err_cnt);
        end
        wr_en = 1'b1; wr_sel = 32'h0; tick(); idle();
        checks++;
        if (err_cnt !== 2'd2 || sel_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_zero_sel got %b/%0d want 1/2", sel_err, err_cnt);
        end
    endtask

    task automatic test_saturation_clear();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_sel = 32'hFFFF0000 >> i; tick();
        end
        idle();
        checks++;
        if (err_cnt !== 2'd3 || sel_err !== 1'b1) begin
            errors++;
            $display("FAIL saturate got %b/%0d want 1/3", sel_err, err_cnt);
        end
        err_clr = 1'b1; tick(); idle();
        checks++;
        if (err_cnt !== 2'd0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL clear got %b/%0d want 0/0", sel_err, err_cnt);
        end
        wr_en = 1'b1; wr_sel = 32'h3; tick(); tick(); idle();
        err_clr = 1'b1; wr_en = 1'b1; wr_sel = 32'h0; tick(); idle();
        checks++;
        if (err_cnt !== 2'd1 || sel_err !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_error got %b/%0d want 1/1", sel_err, err_cnt);
        end
    endtask

    task automatic test_same_cycle();
        logic [WIDTH-1:0] want;
        wr_en = 1'b1; wr_sel = 32'h1 << 7; wr_data = 32'h1; tick();
        wr_data = 32'h2; rd_addr0 = 5'd7; rd_addr1 = 5'd6; #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h2;
`else
        want = 32'h1;
`endif
        checks++;
        if (rd_data0 !== want || rd_data1 !== m_regs[6]) begin
            errors++;
            $display("FAIL same_cycle got %h/%h want %h/%h", rd_data0, rd_data1, want, m_regs[6]);
        end
        tick(); idle(); #1;
        checks++;
        if (rd_data0 !== 32'h2) begin
            errors++;
            $display("FAIL after_write got %h want 2", rd_data0);
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 3);
            wr_en   = (r != 0);
            wr_sel  = (r == 1 || r == 2) ? (32'h1 << $urandom_range(0, 31))
                    : ($urandom_range(0, 3) == 0 ? 32'h0 : 32'($urandom));
            wr_data  = 32'($urandom);
            err_clr  = ($urandom_range(0, 7) == 0);
            rd_addr0 = 5'($urandom_range(0, 31));
            rd_addr1 = $urandom_range(0, 1) ? rd_addr0 : 5'($urandom_range(0, 31));
            if (wr_en && $urandom_range(0, 1) && wr_sel != 0) rd_addr0 = 5'($clog2(wr_sel));
            #1;
            checks++;
            if (rd_data0 !== exp_rd(rd_addr0) || rd_data1 !== exp_rd(rd_addr1)) begin
                errors++;
                $display("FAIL rand_read n=%0d a=%0d/%0d got %h/%h want %h/%h", n, rd_addr0, rd_addr1,
                         rd_data0, rd_data1, exp_rd(rd_addr0), exp_rd(rd_addr1));
            end
            tick();
            checks++;
            if (sel_err !== m_err || int'(err_cnt) != m_cnt) begin
                errors++;
                $display("FAIL rand_err n=%0d got %b/%0d want %b/%0d", n, sel_err, err_cnt, m_err, m_cnt);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; wr_sel = 32'h1 << 9; wr_data = 32'h99; tick();
        wr_sel = 32'h6; tick();
        rst = 1'b1; wr_en = 1'b1; wr_sel = 32'h1 << 9; wr_data = 32'h55; tick();
        rst = 1'b0; wr_sel = 32'hC0; tick(); idle();
        rd_addr0 = 5'd9; #1;
        checks++;
        if (rd_data0 !== '0 || err_cnt !== 2'd1 || sel_err !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got r9=%h %b/%0d want 0 1/1", rd_data0, sel_err, err_cnt);
        end
        err_clr = 1'b1; tick(); idle();
        rst = 1'b1; wr_en = 1'b1; wr_sel = 32'h1 << 9; wr_data = 32'h77; tick(); idle(); #1;
        checks++;
        if (rd_data0 !== '0 || err_cnt !== '0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_override got r9=%h %b/%0d want 0 0/0", rd_data0, sel_err, err_cnt);
        end
        wr_en = 1'b0; wr_sel = 32'hDEADBEEF; wr_data = 32'hBAD; tick();
        wr_sel = 32'h1 << 9; tick(); idle(); #1;
        checks++;
        if (rd_data0 !== '0 || err_cnt !== '0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_en_low got r9=%h %b/%0d want 0 0/0", rd_data0, sel_err, err_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 'x;
        m_err = 1'bx; m_cnt = 0;
        test_reset();
        test_legal_writes();
        test_illegal();
        test_saturation_clear();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
